sattn_cmdq: RTL and testbench

SATTN_CMDQ -- requirements
Module: sattn_cmdq

---
 rtl/sattn_cmdq.sv | 198 +++++++++++++++++++
 tb/tb_sattn_cmdq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sattn_cmdq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sattn_cmdq                                               |
// | Description : MMIO command queue dispatching descriptors to engines.   |
// |               Optional perf counters enabled by SATTN_CMDQ_PERF_EN.    |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module sattn_cmdq #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int QDEPTH     = 4,
    parameter int NUM_ENG    = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  mmio_wen,
    input  logic                  mmio_ren,
    input  logic [ADDR_WIDTH-1:0] mmio_addr,
    input  logic [DATA_WIDTH-1:0] mmio_wdata,
    output logic [DATA_WIDTH-1:0] mmio_rdata,
    output logic [NUM_ENG-1:0]    eng_start,
    output logic [7:0]            eng_op,
    output logic [15:0]           eng_m_rows,
    output logic [15:0]           eng_head_d,
    output logic [15:0]           eng_s_tokens,
    input  logic [NUM_ENG-1:0]    eng_done,
    output logic                  busy,
    output logic                  irq
);
    localparam int         PW        = $clog2(QDEPTH);
    localparam logic [7:0] C_OP_BASE = 8'h14;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_RETIRE = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [55:0]   r_fifo [QDEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [4:0]    r_count;
    logic [15:0]   r_m_rows, r_head_d, r_s_tokens;
    logic [31:0]   r_timeout, r_retired, r_wait_cnt;
    logic [7:0]    r_op;
    logic [15:0]   r_d_m_rows, r_d_head_d, r_d_s_tokens;
    logic          r_irq, r_ovf, r_tmo, r_ill;

    logic               w_push_req, w_full, w_empty, w_push, w_pop, w_drop, w_clr;
    logic               w_legal, w_done_sel, w_tmo_hit, w_ill, w_retire;
    logic [NUM_ENG-1:0] w_sel_oh;
    logic [11:0]        w_status;
    logic               w_unused;

    assign w_unused   = ^{mmio_wdata[DATA_WIDTH-1:32]};
    assign w_full     = (r_count == 5'(QDEPTH));
    assign w_empty    = (r_count == 5'd0);
    assign w_push_req = mmio_wen && (mmio_addr == ADDR_WIDTH'(8'h18)) && (mmio_wdata[7:0] != 8'h00);
    // Fullness is judged on the pre-pop count, so a full queue drops even if a pop coincides.
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_clr      = mmio_wen && (mmio_addr == ADDR_WIDTH'(8'h30)) && mmio_wdata[0];

    always_comb begin
        w_sel_oh = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_sel_oh[i] = (r_op == 8'(C_OP_BASE + 8'(i)));
        end
    end

    assign w_legal    = |w_sel_oh;
    assign w_done_sel = |(eng_done & w_sel_oh);
    assign w_tmo_hit  = (r_state == S_WAIT) && !w_done_sel && (r_timeout != 32'd0)
                        && ((r_wait_cnt + 32'd1) == r_timeout);
    assign w_ill      = (r_state == S_ISSUE) && !w_legal;
    assign w_retire   = (r_state == S_RETIRE);

    always_comb begin
        w_state_nxt = r_state;
        eng_start   = '0;
        case (r_state)
            S_IDLE:   if (!w_empty) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                if (w_legal) begin
                    eng_start   = w_sel_oh;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_RETIRE;
                end
            end
            S_WAIT:   if (w_done_sel || w_tmo_hit) w_state_nxt = S_RETIRE;
            S_RETIRE: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {mmio_wdata[7:0], r_m_rows, r_head_d, r_s_tokens};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_m_rows     <= '0;
            r_head_d     <= '0;
            r_s_tokens   <= '0;
            r_timeout    <= '0;
            r_retired    <= '0;
            r_wait_cnt   <= '0;
            r_op         <= '0;
            r_d_m_rows   <= '0;
            r_d_head_d   <= '0;
            r_d_s_tokens <= '0;
            r_irq        <= 1'b0;
            r_ovf        <= 1'b0;
            r_tmo        <= 1'b0;
            r_ill        <= 1'b0;
        end else begin
            if (mmio_wen && mmio_addr == ADDR_WIDTH'(8'h00)) r_m_rows   <= mmio_wdata[15:0];
            if (mmio_wen && mmio_addr == ADDR_WIDTH'(8'h08)) r_head_d   <= mmio_wdata[15:0];
            if (mmio_wen && mmio_addr == ADDR_WIDTH'(8'h10)) r_s_tokens <= mmio_wdata[15:0];
            if (mmio_wen && mmio_addr == ADDR_WIDTH'(8'h38)) r_timeout  <= mmio_wdata[31:0];
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {r_op, r_d_m_rows, r_d_head_d, r_d_s_tokens} <= r_fifo[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (r_state == S_ISSUE)     r_wait_cnt <= '0;
            else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + 32'd1;
            if (w_retire) r_retired <= r_retired + 32'd1;
            // Set conditions take priority over a same-cycle software clear.
            if (w_retire)       r_irq <= 1'b1;
            else if (w_clr)     r_irq <= 1'b0;
            if (w_drop)         r_ovf <= 1'b1;
            else if (w_clr)     r_ovf <= 1'b0;
            if (w_tmo_hit)      r_tmo <= 1'b1;
            else if (w_clr)     r_tmo <= 1'b0;
            if (w_ill)          r_ill <= 1'b1;
            else if (w_clr)     r_ill <= 1'b0;
        end
    end

`ifdef SATTN_CMDQ_PERF_EN
    logic [63:0] r_perf_wait, r_perf_drop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_wait <= '0;
            r_perf_drop <= '0;
        end else begin
            if (r_state == S_WAIT) r_perf_wait <= r_perf_wait + 64'd1;
            if (w_drop)            r_perf_drop <= r_perf_drop + 64'd1;
        end
    end
`endif

    assign busy         = (r_state != S_IDLE) || !w_empty;
    assign irq          = r_irq;
    assign eng_op       = r_op;
    assign eng_m_rows   = r_d_m_rows;
    assign eng_head_d   = r_d_head_d;
    assign eng_s_tokens = r_d_s_tokens;
    assign w_status     = {r_irq, r_ill, r_tmo, r_ovf, busy, w_empty, w_full, r_count};

    always_comb begin
        mmio_rdata = '0;
        if (mmio_ren) begin
            case (mmio_addr)
                ADDR_WIDTH'(8'h00): mmio_rdata = DATA_WIDTH'(r_m_rows);
                ADDR_WIDTH'(8'h08): mmio_rdata = DATA_WIDTH'(r_head_d);
                ADDR_WIDTH'(8'h10): mmio_rdata = DATA_WIDTH'(r_s_tokens);
                ADDR_WIDTH'(8'h20): mmio_rdata = DATA_WIDTH'(w_status);
                ADDR_WIDTH'(8'h28): mmio_rdata = DATA_WIDTH'(r_retired);
                ADDR_WIDTH'(8'h38): mmio_rdata = DATA_WIDTH'(r_timeout);
`ifdef SATTN_CMDQ_PERF_EN
                ADDR_WIDTH'(8'h40): mmio_rdata = DATA_WIDTH'(r_perf_wait);
                ADDR_WIDTH'(8'h48): mmio_rdata = DATA_WIDTH'(r_perf_drop);
`endif
                default:            mmio_rdata = '0;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sattn_cmdq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_sattn_cmdq                                            |
// | Description : Directed self-checking bench for sattn_cmdq.             |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module tb_sattn_cmdq;
    localparam int AW = 16;
    localparam int DW = 64;
    localparam int QD = 4;
    localparam int NE = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          mmio_wen = 1'b0;
    logic          mmio_ren = 1'b0;
    logic [AW-1:0] mmio_addr = '0;
    logic [DW-1:0] mmio_wdata = '0;
    logic [DW-1:0] mmio_rdata;
    logic [NE-1:0] eng_start;
    logic [7:0]    eng_op;
    logic [15:0]   eng_m_rows, eng_head_d, eng_s_tokens;
    logic [NE-1:0] eng_done = '0;
    logic          busy, irq;

    int n_tests = 0;
    int n_fail  = 0;

    sattn_cmdq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QDEPTH(QD), .NUM_ENG(NE)) dut (
        .clk(clk), .rstn(rstn), .mmio_wen(mmio_wen), .mmio_ren(mmio_ren),
        .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_rdata(mmio_rdata),
        .eng_start(eng_start), .eng_op(eng_op), .eng_m_rows(eng_m_rows),
        .eng_head_d(eng_head_d), .eng_s_tokens(eng_s_tokens), .eng_done(eng_done),
        .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; the write is captured by the next rising edge.
    task automatic wr(input logic [15:0] a, input logic [63:0] d);
        mmio_wen = 1'b1; mmio_addr = a; mmio_wdata = d;
        @(negedge clk);
        mmio_wen = 1'b0; mmio_addr = '0; mmio_wdata = '0;
    endtask

    task automatic rdchk(input string tag, input logic [15:0] a, input logic [63:0] exp);
        logic [63:0] v;
        mmio_ren = 1'b1; mmio_addr = a;
        #1 v = mmio_rdata;
        mmio_ren = 1'b0; mmio_addr = '0;
        chk(tag, v, exp);
    endtask

    task automatic serve(input int idx);
        int k;
        k = 0;
        while (eng_start !== NE'(1 << idx) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("start_seen", 64'(k < 30), 64'd1);
        @(negedge clk);
        eng_done = NE'(1 << idx);
        @(negedge clk);
        eng_done = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_start", 64'(eng_start), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        rdchk("rst_status", 16'h20, 64'h40);
        rdchk("rst_retired", 16'h28, 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single command to engine 0, done 5 cycles after start
        wr(16'h00, 64'd4);
        wr(16'h08, 64'd8);
        wr(16'h10, 64'd16);
        rdchk("stage_mrows", 16'h00, 64'd4);
        wr(16'h18, 64'h14);
        chk("t1_nostart_yet", 64'(eng_start), 64'd0);
        chk("t1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("t1_start", 64'(eng_start), 64'b001);
        chk("t1_desc", {eng_op, eng_m_rows, eng_head_d, eng_s_tokens[7:0]},
            {8'h14, 16'd4, 16'd8, 8'd16});
        @(negedge clk);
        chk("t1_start_once", 64'(eng_start), 64'd0);
        eng_done = 3'b110;
        @(negedge clk);
        eng_done = '0;
        repeat (3) @(negedge clk);
        eng_done = 3'b001;
        @(negedge clk);
        eng_done = '0;
        rdchk("t1_retired_pre", 16'h28, 64'd0);
        chk("t1_desc_hold", 64'(eng_m_rows), 64'd4);
        @(negedge clk);
        rdchk("t1_retired", 16'h28, 64'd1);
        chk("t1_irq", 64'(irq), 64'd1);
        chk("t1_idle", 64'(busy), 64'd0);
        rdchk("t1_status", 16'h20, 64'h840);
        wr(16'h30, 64'd1);
        chk("t1_irq_clr", 64'(irq), 64'd0);

        // Timeout on engine 1 with a second command queued behind it
        wr(16'h38, 64'd10);
        rdchk("timeout_rb", 16'h38, 64'd10);
        wr(16'h18, 64'h15);
        wr(16'h18, 64'h16);
        chk("t2_start", 64'(eng_start), 64'b010);
        rdchk("t2_status_issue", 16'h20, 64'h81);
        repeat (10) @(negedge clk);
        rdchk("t2_no_tmo_yet", 16'h20, 64'h81);
        @(negedge clk);
        rdchk("t2_tmo", 16'h20, 64'h281);
        @(negedge clk);
        rdchk("t2_retired", 16'h28, 64'd2);
        @(negedge clk);
        chk("t2_next_start", 64'(eng_start), 64'b100);
        chk("t2_next_op", 64'(eng_op), 64'h16);
        @(negedge clk);
        eng_done = 3'b100;
        @(negedge clk);
        eng_done = '0;
        @(negedge clk);
        rdchk("t2_retired2", 16'h28, 64'd3);
        wr(16'h30, 64'd1);
        rdchk("t2_clr_status", 16'h20, 64'h40);

        // Illegal opcode
        wr(16'h18, 64'h20);
        @(negedge clk);
        chk("t3_no_start", 64'(eng_start), 64'd0);
        @(negedge clk);
        rdchk("t3_ill", 16'h20, 64'h4C0);
        @(negedge clk);
        rdchk("t3_retired", 16'h28, 64'd4);
        rdchk("t3_status", 16'h20, 64'hC40);
        wr(16'h30, 64'd1);
        rdchk("t3_clr_status", 16'h20, 64'h40);
        chk("t3_irq_clr", 64'(irq), 64'd0);

        // Overflow while engine 1 is stalled
        wr(16'h38, 64'd0);
        wr(16'h18, 64'h15);
        @(negedge clk);
        chk("t4_start", 64'(eng_start), 64'b010);
        @(negedge clk);
        for (int i = 0; i < QD + 1; i++) wr(16'h18, 64'h15);
        rdchk("t4_full_ovf", 16'h20, 64'h1A4);
        eng_done = 3'b010;
        @(negedge clk);
        eng_done = '0;
        for (int i = 0; i < QD; i++) serve(1);
        @(negedge clk);
        rdchk("t4_retired", 16'h28, 64'd9);
        rdchk("t4_status", 16'h20, 64'h940);
        rdchk("unmapped", 16'h50, 64'd0);

        // Reset while in WAIT with two commands queued
        wr(16'h18, 64'h14);
        wr(16'h18, 64'h15);
        wr(16'h18, 64'h16);
        rdchk("t5_pre_status", 16'h20, 64'h982);
        rstn = 1'b0;
        #1;
        chk("t5_outs", {32'(eng_start), eng_op, eng_m_rows, 6'd0, busy, irq}, 64'd0);
        rdchk("t5_status", 16'h20, 64'h40);
        rdchk("t5_retired", 16'h28, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        wr(16'h18, 64'h14);
        chk("t5_no_start", 64'(eng_start), 64'd0);
        @(negedge clk);
        chk("t5_start", 64'(eng_start), 64'b001);

        // 7-cycle WAIT with one dropped push, then the optional counters
        @(negedge clk);
        for (int i = 0; i < QD + 1; i++) wr(16'h18, 64'h15);
        @(negedge clk);
        eng_done = 3'b001;
        @(negedge clk);
        eng_done = '0;
        rdchk("t6_status", 16'h20, 64'h1A4);
`ifdef SATTN_CMDQ_PERF_EN
        rdchk("perf_wait", 16'h40, 64'd7);
        rdchk("perf_drop", 16'h48, 64'd1);
`else
        rdchk("perf_wait", 16'h40, 64'd0);
        rdchk("perf_drop", 16'h48, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
